// File: rtl/mips_memory_stage_buffered_pkg.sv
// Shared definitions for the buffered MIPS memory stage.
// Holds the word/lane geometry, the access-size encodings, the load FSM state
// encoding and the store-queue entry layout together with a helper that packs one.
package mips_memory_stage_buffered_pkg;

  localparam int WORD_W = 32;
  localparam int BYTES  = WORD_W / 8;
  localparam int LANE_W = $clog2(BYTES);
  localparam int ADDR_L = 64;
  localparam int ADDR_W = $clog2(ADDR_L);
  localparam int STQ_D  = 4;
  localparam int CNT_W  = $clog2(STQ_D + 1);

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_WAIT = 2'd1,
    LD_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] index;
    logic [BYTES-1:0]  bytes;
    logic [WORD_W-1:0] data;
  } store_entry_t;

  localparam int ENTRY_W = $bits(store_entry_t);

  function automatic store_entry_t packEntry(input logic [ADDR_W-1:0] index,
                                             input logic [BYTES-1:0]  bytes,
                                             input logic [WORD_W-1:0] data);
    store_entry_t e;
    e.index = index;
    e.bytes = bytes;
    e.data  = data;
    return e;
  endfunction

endpackage

// File: rtl/mips_memory_stage_buffered_if.sv
// Signal bundle between the memory stage, the ExMem/MemWb pipeline and the word memory.
// master: the memory stage (consumes pipeline inputs and memory responses, drives the rest).
// slave : the surrounding pipeline and memory.
// Handshake: memReq and every mem* output are held stable from the cycle memReq rises
// until the cycle memAck is high; that cycle completes the transfer. memAck is never
// returned in the cycle memReq first rises. memRdata is meaningful only with memAck on a read.
// dbgState/dbgCount expose the load FSM state and the store queue occupancy.
interface mips_memory_stage_buffered_if;
  import mips_memory_stage_buffered_pkg::*;

  logic              inValid;
  logic              inLoad;
  logic              inStore;
  logic [1:0]        inSize;
  logic              inSigned;
  logic [WORD_W-1:0] inAddr;
  logic [WORD_W-1:0] inData;
  logic              stall;
  logic              outValid;
  logic [WORD_W-1:0] out;
  logic              fault;
  logic              memReq;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [BYTES-1:0]  memBytes;
  logic [WORD_W-1:0] memWdata;
  logic              memAck;
  logic [WORD_W-1:0] memRdata;
  state_t            dbgState;
  logic [CNT_W-1:0]  dbgCount;

  modport master (
    input  inValid, inLoad, inStore, inSize, inSigned, inAddr, inData, memAck, memRdata,
    output stall, outValid, out, fault, memReq, memWe, memAddr, memBytes, memWdata,
           dbgState, dbgCount
  );

  modport slave (
    output inValid, inLoad, inStore, inSize, inSigned, inAddr, inData, memAck, memRdata,
    input  stall, outValid, out, fault, memReq, memWe, memAddr, memBytes, memWdata,
           dbgState, dbgCount
  );

endinterface

// File: rtl/mips_memory_store_queue.sv
// Circular FIFO of posted stores.
// Ports: push/pushData enqueue (ignored when full), pop dequeues (ignored when empty),
// headData is the oldest entry, count/full/empty reflect the registered occupancy.
// Async active-high reset empties the queue; entry storage itself is not reset.
module mips_memory_store_queue #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [W-1:0]                 pushData,
  input  logic                         pop,
  output logic [W-1:0]                 headData,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     slots [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             doPush;
  logic             doPop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign doPush   = push & ~full;
  assign doPop    = pop & ~empty;
  assign headData = slots[head];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (doPush) tail <= bump(tail);
      if (doPop)  head <= bump(head);
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) slots[tail] <= pushData;
  end

endmodule

// File: rtl/mips_memory_stage_buffered.sv
// Buffered MIPS memory stage: posts stores into a queue, serialises loads behind
// queued stores, and extracts/extends byte and halfword load data.
// Ports: clk, rst (async, active-high) and the bus interface (master side):
// pipeline inputs in*, stall/outValid/out/fault back to the pipeline, and the
// request/acknowledge word-memory port mem*. dbgState/dbgCount expose internal state.
module mips_memory_stage_buffered
  import mips_memory_stage_buffered_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  mips_memory_stage_buffered_if.master bus
);

  state_t            state, stateNext;
  logic [LANE_W-1:0] lane;
  logic [ADDR_W-1:0] index;
  logic [LANE_W+2:0] laneShift;
  logic              aligned, memOp, legal, loadOk, storeOk, illegal;
  logic [BYTES-1:0]  sizedMask;
  logic [WORD_W-1:0] sizedData, rdShift, loadVal, outReg;
  store_entry_t      pushEntry, head;
  logic [ENTRY_W-1:0] headData;
  logic [CNT_W-1:0]  count;
  logic              full, empty, pop;
  logic              unusedAddrHi;

  assign lane      = bus.inAddr[LANE_W-1:0];
  assign index     = bus.inAddr[LANE_W+ADDR_W-1:LANE_W];
  assign laneShift = {lane, 3'b000};
  // Address bits above the word index are ignored so the index wraps.
  assign unusedAddrHi = ^bus.inAddr[WORD_W-1:LANE_W+ADDR_W];

  always_comb begin
    aligned = 1'b0;
    case (bus.inSize)
      SIZE_BYTE: aligned = 1'b1;
      SIZE_HALF: aligned = ~lane[0];
      SIZE_WORD: aligned = (lane == '0);
      default:   aligned = 1'b0;
    endcase
  end

  // Gating with rst keeps every combinational output at 0 while reset is held.
  assign memOp   = bus.inValid & (bus.inLoad | bus.inStore) & ~rst;
  assign legal   = aligned & ~(bus.inLoad & bus.inStore);
  assign loadOk  = memOp & legal & bus.inLoad;
  assign storeOk = memOp & legal & bus.inStore;
  assign illegal = memOp & ~legal;

  // Store data is trimmed to the access size before being moved to its lane.
  always_comb begin
    sizedMask = '1;
    sizedData = bus.inData;
    case (bus.inSize)
      SIZE_BYTE: begin
        sizedMask = BYTES'(1);
        sizedData = WORD_W'(bus.inData[7:0]);
      end
      SIZE_HALF: begin
        sizedMask = BYTES'(3);
        sizedData = WORD_W'(bus.inData[15:0]);
      end
      default: ;
    endcase
  end

  assign pushEntry = packEntry(index, sizedMask << lane, sizedData << laneShift);
  assign head      = store_entry_t'(headData);
  // Stores drain only while no load owns the memory port.
  assign pop       = (state == IDLE) & ~empty & bus.memAck;

  mips_memory_store_queue #(.DEPTH(STQ_D), .W(ENTRY_W)) u_stq (
    .clk      (clk),
    .rst      (rst),
    .push     (storeOk),
    .pushData (pushEntry),
    .pop      (pop),
    .headData (headData),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  always_comb begin
    rdShift = bus.memRdata >> laneShift;
    case (bus.inSize)
      SIZE_BYTE: loadVal = {{(WORD_W-8){bus.inSigned & rdShift[7]}}, rdShift[7:0]};
      SIZE_HALF: loadVal = {{(WORD_W-16){bus.inSigned & rdShift[15]}}, rdShift[15:0]};
      default:   loadVal = rdShift;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      outReg <= '0;
    end else begin
      state <= stateNext;
      if (state == LD_WAIT && bus.memAck) outReg <= loadVal;
    end
  end

  always_comb begin
    stateNext    = state;
    bus.stall    = 1'b0;
    bus.outValid = 1'b0;
    bus.memReq   = 1'b0;
    bus.memWe    = 1'b0;
    bus.memAddr  = '0;
    bus.memBytes = '0;
    bus.memWdata = '0;
    case (state)
      IDLE: begin
        // The store queue owns the port first so a load never overtakes an older store.
        if (!empty) begin
          bus.memReq   = 1'b1;
          bus.memWe    = 1'b1;
          bus.memAddr  = head.index;
          bus.memBytes = head.bytes;
          bus.memWdata = head.data;
        end
        if (loadOk) begin
          bus.stall = 1'b1;
          if (empty) begin
            bus.memReq  = 1'b1;
            bus.memAddr = index;
            stateNext   = LD_WAIT;
          end
        end
        // Fullness uses the registered count; a pop this cycle does not free a slot yet.
        if (storeOk && full) bus.stall = 1'b1;
      end
      LD_WAIT: begin
        bus.stall   = 1'b1;
        bus.memReq  = 1'b1;
        bus.memAddr = index;
        if (bus.memAck) stateNext = LD_DONE;
      end
      LD_DONE: begin
        bus.outValid = 1'b1;
        stateNext    = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign bus.fault    = illegal;
  assign bus.out      = outReg;
  assign bus.dbgState = state;
  assign bus.dbgCount = count;

endmodule

// File: tb/tb_mips_memory_stage_buffered.sv
module tb_mips_memory_stage_buffered;
  import mips_memory_stage_buffered_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mips_memory_stage_buffered_if bus ();
  mips_memory_stage_buffered dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;
  int ackMode = 1;          // 0: never ack, 1: ack as early as allowed, 2: random
  int reqAge  = 0;
  logic [7:0]        refMem  [ADDR_L*BYTES];
  logic [7:0]        refSnap [ADDR_L*BYTES];
  logic [WORD_W-1:0] memWords [ADDR_L];
  logic [WORD_W-1:0] exp_q[$];

  function automatic logic [31:0] initWord(input int w);
    return (32'h9E3779B9 * 32'(w)) ^ 32'h5A5A0F0F;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  initial begin
    for (int w = 0; w < ADDR_L; w++) memWords[w] = initWord(w);
    bus.memAck   = 1'b0;
    bus.memRdata = '0;
    forever begin
      @(negedge clk);
      if (bus.memReq && bus.memAck) begin
        if (bus.memWe)
          for (int b = 0; b < BYTES; b++)
            if (bus.memBytes[b]) memWords[bus.memAddr][8*b +: 8] = bus.memWdata[8*b +: 8];
        reqAge = 0;
      end else if (bus.memReq) reqAge++;
      else reqAge = 0;
      @(posedge clk);
      #2;
      bus.memAck   = bus.memReq && (reqAge >= 1) &&
                     (ackMode == 1 || (ackMode == 2 && $urandom_range(0, 1) == 1));
      bus.memRdata = memWords[bus.memAddr];
    end
  end

  always @(negedge clk)
    if (rst === 1'b0) check("count_bound", 64'(bus.dbgCount <= CNT_W'(STQ_D)), 64'd1);

  // ---------------- reference model (byte-addressed memory) ----------------
  function automatic int byteBase(input logic [31:0] a);
    return (int'(a >> 2) % ADDR_L) * BYTES + int'(a[1:0]);
  endfunction

  function automatic logic refLegal(input logic ld, st, input logic [1:0] sz, input logic [31:0] a);
    if (ld && st) return 1'b0;
    case (sz)
      2'd0:    return 1'b1;
      2'd1:    return a[0] == 1'b0;
      2'd2:    return a[1:0] == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] refLoad(input logic [1:0] sz, input logic sg, input logic [31:0] a);
    int b;
    logic [15:0] h;
    b = byteBase(a);
    h = {refMem[b+1 < ADDR_L*BYTES ? b+1 : b], refMem[b]};
    case (sz)
      2'd0:    return {{24{sg & refMem[b][7]}}, refMem[b]};
      2'd1:    return {{16{sg & h[15]}}, h};
      default: return {refMem[b+3], refMem[b+2], refMem[b+1], refMem[b]};
    endcase
  endfunction

  task automatic refStore(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    int b, n;
    b = byteBase(a);
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    for (int i = 0; i < n; i++) refMem[b+i] = d[8*i +: 8];
  endtask

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered and left at posedge+1. Holds the op until stall drops, then checks it.
  task automatic doOp(input logic ld, st, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, d, input string tag, output int waitCycles);
    logic legal;
    legal = refLegal(ld, st, sz, a);
    bus.inValid = 1'b1; bus.inLoad = ld; bus.inStore = st;
    bus.inSize = sz; bus.inSigned = sg; bus.inAddr = a; bus.inData = d;
    if (legal && ld) exp_q.push_back(refLoad(sz, sg, a));
    waitCycles = 0;
    @(negedge clk);
    if (!legal) check({tag, "_fault"}, 64'(bus.fault), 64'd1);
    while (bus.stall === 1'b1 && waitCycles < 300) begin
      @(negedge clk);
      waitCycles++;
    end
    check({tag, "_stall_bound"}, 64'(waitCycles < 300), 64'd1);
    if (!legal) check({tag, "_no_stall"}, 64'(waitCycles), 64'd0);
    else check({tag, "_no_fault"}, 64'(bus.fault), 64'd0);
    if (legal && ld) begin
      check({tag, "_outValid"}, 64'(bus.outValid), 64'd1);
      check({tag, "_out"}, 64'(bus.out), 64'(exp_q.pop_front()));
      check({tag, "_min_latency"}, 64'(waitCycles >= 2), 64'd1);
    end
    if (legal && st) refStore(sz, a, d);
    step();
    bus.inValid = 1'b0; bus.inLoad = 1'b0; bus.inStore = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int w;
    logic [31:0] a, d, expWord;
    logic [1:0] sz;
    logic ld;

    bus.inValid = 1'b0; bus.inLoad = 1'b0; bus.inStore = 1'b0; bus.inSize = 2'd0;
    bus.inSigned = 1'b0; bus.inAddr = '0; bus.inData = '0;
    for (int i = 0; i < ADDR_L; i++)
      for (int b = 0; b < BYTES; b++) refMem[i*BYTES+b] = initWord(i) >> (8*b);

    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_stall",    64'(bus.stall),    64'd0);
    check("rst_outValid", 64'(bus.outValid), 64'd0);
    check("rst_out",      64'(bus.out),      64'd0);
    check("rst_fault",    64'(bus.fault),    64'd0);
    check("rst_memReq",   64'(bus.memReq),   64'd0);
    check("rst_memWe",    64'(bus.memWe),    64'd0);
    check("rst_memAddr",  64'(bus.memAddr),  64'd0);
    check("rst_memBytes", 64'(bus.memBytes), 64'd0);
    check("rst_memWdata", 64'(bus.memWdata), 64'd0);
    check("rst_count",    64'(bus.dbgCount), 64'd0);
    check("rst_state",    64'(bus.dbgState), 64'(IDLE));
    step();
    rst = 1'b0;

    // SW posts without stalling; request appears the next cycle.
    doOp(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, "sw", w);
    check("sw_zero_stall", 64'(w), 64'd0);
    @(negedge clk);
    check("sw_memReq",   64'(bus.memReq),   64'd1);
    check("sw_memWe",    64'(bus.memWe),    64'd1);
    check("sw_memAddr",  64'(bus.memAddr),  64'd4);
    check("sw_memBytes", 64'(bus.memBytes), 64'hF);
    check("sw_memWdata", 64'(bus.memWdata), 64'hDEADBEEF);
    step();
    repeat (3) step();

    // SB then LBU at the same byte: load waits for the drain.
    doOp(1'b0, 1'b1, 2'd0, 1'b0, 32'h13, 32'hFFFFFFAB, "sb", w);
    doOp(1'b1, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, "lbu", w);
    check("lbu_drain_wait", 64'(w), 64'd4);
    @(negedge clk);
    check("lbu_out_const", 64'(bus.out), 64'h000000AB);
    check("lbu_pulse_end", 64'(bus.outValid), 64'd0);
    step();

    // Halfword sign/zero extension.
    doOp(1'b0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h80010000, "sw_seed", w);
    repeat (3) step();
    doOp(1'b1, 1'b0, 2'd1, 1'b1, 32'h22, 32'h0, "lh", w);
    check("lh_latency", 64'(w), 64'd2);
    check("lh_out_const", 64'(bus.out), 64'hFFFF8001);
    doOp(1'b1, 1'b0, 2'd1, 1'b0, 32'h22, 32'h0, "lhu", w);
    check("lhu_out_const", 64'(bus.out), 64'h00008001);

    // Fill the queue with the memory silent; the fifth store must wait.
    ackMode = 0;
    for (int i = 0; i < STQ_D; i++) begin
      doOp(1'b0, 1'b1, 2'd2, 1'b0, 32'h40 + 32'(4*i), $urandom, "sw_fill", w);
      check("sw_fill_no_stall", 64'(w), 64'd0);
    end
    fork
      begin
        repeat (6) @(posedge clk);
        #1 ackMode = 1;
      end
    join_none
    doOp(1'b0, 1'b1, 2'd2, 1'b0, 32'h50, $urandom, "sw_full", w);
    check("sw_full_stalled", 64'(w >= 5), 64'd1);
    repeat (12) step();

    // Misaligned word: fault pulse, no stall, no request.
    bus.inValid = 1'b1; bus.inLoad = 1'b1; bus.inStore = 1'b0;
    bus.inSize = 2'd2; bus.inAddr = 32'h06;
    @(negedge clk);
    check("lw_mis_fault",  64'(bus.fault),  64'd1);
    check("lw_mis_stall",  64'(bus.stall),  64'd0);
    check("lw_mis_memReq", 64'(bus.memReq), 64'd0);
    step();
    bus.inValid = 1'b0; bus.inLoad = 1'b0;
    @(negedge clk);
    check("lw_mis_pulse_end", 64'(bus.fault), 64'd0);
    step();
    doOp(1'b0, 1'b1, 2'd3, 1'b0, 32'h00, 32'h1, "size3", w);
    doOp(1'b1, 1'b1, 2'd0, 1'b0, 32'h00, 32'h1, "ld_and_st", w);
    doOp(1'b0, 1'b1, 2'd1, 1'b0, 32'h21, 32'h1, "sh_mis", w);

    // Reset with two stores queued and a load waiting behind them.
    ackMode = 0;
    refSnap = refMem;
    doOp(1'b0, 1'b1, 2'd2, 1'b0, 32'h60, 32'h11112222, "sw_q1", w);
    doOp(1'b0, 1'b1, 2'd2, 1'b0, 32'h64, 32'h33334444, "sw_q2", w);
    bus.inValid = 1'b1; bus.inLoad = 1'b1; bus.inSize = 2'd2; bus.inAddr = 32'h08;
    @(negedge clk);
    check("rstq_stall", 64'(bus.stall),    64'd1);
    check("rstq_count", 64'(bus.dbgCount), 64'd2);
    check("rstq_drain_first", 64'(bus.memWe), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("rstq_memReq_drop", 64'(bus.memReq),   64'd0);
    check("rstq_count_clr",   64'(bus.dbgCount), 64'd0);
    bus.inValid = 1'b0; bus.inLoad = 1'b0;
    step();
    rst = 1'b0;
    refMem = refSnap;
    repeat (3) begin
      @(negedge clk);
      check("rstq_no_outValid", 64'(bus.outValid), 64'd0);
      check("rstq_idle", 64'(bus.dbgState), 64'(IDLE));
      step();
    end

    // Reset while the load sits in LD_WAIT.
    bus.inValid = 1'b1; bus.inLoad = 1'b1; bus.inSize = 2'd2; bus.inAddr = 32'h00;
    step();
    @(negedge clk);
    check("rstw_in_wait", 64'(bus.dbgState), 64'(LD_WAIT));
    #1 rst = 1'b1;
    #1;
    check("rstw_memReq_drop", 64'(bus.memReq), 64'd0);
    check("rstw_state_idle",  64'(bus.dbgState), 64'(IDLE));
    bus.inValid = 1'b0; bus.inLoad = 1'b0;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rstw_no_outValid", 64'(bus.outValid), 64'd0);
    step();

    // Randomized traffic on a few words with random memory latency.
    ackMode = 2;
    for (int i = 0; i < 150; i++) begin
      ld = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 2));
      a  = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2);
      if (sz == 2'd0) a[1:0] = 2'($urandom_range(0, 3));
      if (sz == 2'd1) a[1] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) a[0] = 1'b1;
      if ($urandom_range(0, 19) == 0) sz = 2'd3;
      d = $urandom;
      doOp(ld, ~ld, sz, 1'($urandom_range(0, 1)), a, d, ld ? "rnd_ld" : "rnd_st", w);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) step();
    end

    ackMode = 1;
    repeat (12) step();
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < ADDR_L; i++) begin
      expWord = {refMem[i*4+3], refMem[i*4+2], refMem[i*4+1], refMem[i*4]};
      check("mem_word", 64'(memWords[i]), 64'(expWord));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
